// File: rtl/dds_gen.sv
// dds_gen: multi-waveform direct digital synthesis generator.
// A wide phase accumulator drives sine/triangle/sawtooth/square mapping through
// a two-stage output pipeline (offset phase, then waveform sample). A new tuning
// word is only adopted on a phase wrap, so a running tone never changes
// frequency mid-period.
module dds_gen #(
    parameter int phase_width    = 16,
    parameter int data_width     = 8,
    parameter int lut_addr_width = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [1:0]             control,
    input  logic [phase_width-1:0] phase_incr,
    input  logic                   incr_load,
    input  logic [phase_width-1:0] phase_offset,
    output logic [phase_width-1:0] phase_out,
    output logic [data_width-1:0]  signal_out,
    output logic                   signal_valid,
    output logic                   wrap
);

    localparam int IdxWidth    = lut_addr_width - 2;
    localparam int QuarterSize = 2 ** IdxWidth;

    localparam logic [data_width-1:0] Midscale    = {1'b1, {(data_width-1){1'b0}}};
    localparam logic [data_width-1:0] MidMinusOne = {1'b0, {(data_width-1){1'b1}}};

    typedef enum logic [1:0] {
        WaveSquare   = 2'd0,
        WaveSawtooth = 2'd1,
        WaveTriangle = 2'd2,
        WaveSine     = 2'd3
    } wave_e;

    // Quarter-wave sine entry: round(amp * sin(pi/2 * (k+0.5)/N)), evaluated with a
    // 2^30 fixed-point Taylor series so the table is built purely at elaboration.
    function automatic logic [data_width-2:0] sineEntry(input int k);
        longint x;
        longint term;
        longint sum;
        longint amp;
        longint scaled;
        x    = (64'sd3373259426 * longint'(2 * k + 1)) / longint'(4 * QuarterSize);
        term = x;
        sum  = x;
        for (int n = 1; n <= 10; n++) begin
            term = -(((term * x) >>> 30) * x >>> 30) / longint'((2 * n) * (2 * n + 1));
            sum  = sum + term;
        end
        amp    = longint'(2 ** (data_width - 1) - 1);
        scaled = (amp * sum + (64'sd1 <<< 29)) >>> 30;
        return scaled[data_width-2:0];
    endfunction

    logic [data_width-2:0] sineRom [QuarterSize];

    for (genvar k = 0; k < QuarterSize; k++) begin : g_rom
        localparam logic [data_width-2:0] Entry = sineEntry(k);
        assign sineRom[k] = Entry;
    end

    logic [phase_width-1:0] acc_q, acc_d;
    logic [phase_width-1:0] incrActive_q, incrActive_d;
    logic [phase_width-1:0] incrPending_q, incrPending_d;
    logic [phase_width-1:0] p_q, p_d;
    logic [data_width-1:0]  signalOut_q, signalOut_d;
    logic                   wrap_q, wrap_d;
    logic [1:0]             valid_q, valid_d;

    logic [phase_width:0]    accSum;
    logic                    carry;
    logic [lut_addr_width-1:0] sineT;
    logic [1:0]              sineQuad;
    logic [IdxWidth-1:0]     sineIdx;
    logic [IdxWidth-1:0]     sineAddr;
    logic [data_width-2:0]   sineMag;
    logic [data_width-1:0]   triBits;
    wave_e                   waveSel;
    logic                    unusedPhaseBits;

    assign accSum = {1'b0, acc_q} + {1'b0, incrActive_q};
    assign carry  = en & accSum[phase_width];
    assign waveSel = wave_e'(control);
    assign unusedPhaseBits = ^p_q;

    // Accumulator advance, wrap detection and glitch-free adoption of tuning words.
    always_comb begin
        acc_d         = acc_q;
        incrActive_d  = incrActive_q;
        incrPending_d = incrPending_q;
        wrap_d        = carry;
        if (en) begin
            acc_d = accSum[phase_width-1:0];
        end
        if (incr_load) begin
            incrPending_d = phase_incr;
        end
        if (incr_load && (!en || carry)) begin
            incrActive_d = phase_incr;
        end else if (carry) begin
            incrActive_d = incrPending_q;
        end
        p_d     = acc_q + phase_offset;
        valid_d = {valid_q[0], en};
    end

    // Waveform mapping of the offset phase into an offset-binary sample.
    always_comb begin
        sineT    = p_q[phase_width-1 -: lut_addr_width];
        sineQuad = sineT[lut_addr_width-1 -: 2];
        sineIdx  = sineT[IdxWidth-1:0];
        sineAddr = sineQuad[0] ? ~sineIdx : sineIdx;
        sineMag  = sineRom[sineAddr];
        triBits  = p_q[phase_width-2 -: data_width];
        signalOut_d = '0;
        case (waveSel)
            WaveSquare:   signalOut_d = p_q[phase_width-1] ? '0 : '1;
            WaveSawtooth: signalOut_d = p_q[phase_width-1 -: data_width];
            WaveTriangle: signalOut_d = p_q[phase_width-1] ? ~triBits : triBits;
            WaveSine:     signalOut_d = sineQuad[1] ? (MidMinusOne - {1'b0, sineMag})
                                                    : (Midscale + {1'b0, sineMag});
            default:      signalOut_d = '0;
        endcase
    end

    // State registers; reset clears everything, including a same-cycle load.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q         <= '0;
            incrActive_q  <= '0;
            incrPending_q <= '0;
            p_q           <= '0;
            signalOut_q   <= '0;
            wrap_q        <= 1'b0;
            valid_q       <= '0;
        end else begin
            acc_q         <= acc_d;
            incrActive_q  <= incrActive_d;
            incrPending_q <= incrPending_d;
            p_q           <= p_d;
            signalOut_q   <= signalOut_d;
            wrap_q        <= wrap_d;
            valid_q       <= valid_d;
        end
    end

    assign phase_out    = acc_q;
    assign signal_out   = signalOut_q;
    assign signal_valid = valid_q[1];
    assign wrap         = wrap_q;

endmodule

// File: tb/tb_dds_gen.sv
// tb_dds_gen: table-driven, directed and randomized checks of dds_gen against a
// cycle-level arithmetic reference model.
module tb_dds_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [1:0]  control;
    logic [15:0] phase_incr;
    logic        incr_load;
    logic [15:0] phase_offset;
    logic [15:0] phase_out;
    logic [7:0]  signal_out;
    logic        signal_valid;
    logic        wrap;

    int checkCount = 0;
    int passCount  = 0;

    int mAcc = 0, mActive = 0, mPending = 0, mP = 0, mSig = 0, mWrap = 0, mV1 = 0, mV2 = 0;

    int hist [300];
    int sineAt [256];

    typedef struct {
        logic        r;
        logic        e;
        logic [1:0]  c;
        logic [15:0] inc;
        logic        ld;
        logic [15:0] off;
        int          ePhase;
        int          eSig;
        int          eValid;
        int          eWrap;
    } vec_t;

    vec_t vecs [8];

    dds_gen #(.phase_width(16), .data_width(8), .lut_addr_width(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .control      (control),
        .phase_incr   (phase_incr),
        .incr_load    (incr_load),
        .phase_offset (phase_offset),
        .phase_out    (phase_out),
        .signal_out   (signal_out),
        .signal_valid (signal_valid),
        .wrap         (wrap)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    function automatic int refWave(input int p, input int c);
        int t;
        int quad;
        int idx;
        int addr;
        int mag;
        case (c)
            0: return (p >= 32768) ? 0 : 255;
            1: return p / 256;
            2: return (p >= 32768) ? 255 - ((p - 32768) / 128) : p / 128;
            default: begin
                t    = p / 256;
                quad = t / 64;
                idx  = t % 64;
                addr = (quad % 2 == 1) ? 63 - idx : idx;
                mag  = int'($floor(127.0 * $sin(3.14159265358979 * (real'(addr) + 0.5) / 128.0) + 0.5));
                return (quad >= 2) ? 127 - mag : 128 + mag;
            end
        endcase
    endfunction

    task automatic modelStep();
        int sum;
        int carry;
        int newP;
        int newSig;
        if (rst) begin
            mAcc = 0; mActive = 0; mPending = 0; mP = 0;
            mSig = 0; mWrap = 0; mV1 = 0; mV2 = 0;
        end else begin
            newP   = (mAcc + int'(phase_offset)) % 65536;
            newSig = refWave(mP, int'(control));
            sum    = mAcc + mActive;
            carry  = (en && sum >= 65536) ? 1 : 0;
            mV2 = mV1;
            mV1 = en ? 1 : 0;
            if (en) mAcc = sum % 65536;
            mWrap = carry;
            if (incr_load) begin
                if (!en || carry != 0) mActive = int'(phase_incr);
                mPending = int'(phase_incr);
            end else if (carry != 0) begin
                mActive = mPending;
            end
            mP   = newP;
            mSig = newSig;
        end
    endtask

    task automatic applyStimulus(input logic r, input logic e, input logic [1:0] c,
                                 input logic [15:0] inc, input logic ld, input logic [15:0] off);
        rst = r; en = e; control = c; phase_incr = inc; incr_load = ld; phase_offset = off;
        @(posedge clk);
        modelStep();
        #1;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        checkCount++;
        if (actual == expected) passCount++;
        else $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, "_phase"}, int'(phase_out), mAcc);
        checkOutput({tag, "_signal"}, int'(signal_out), mSig);
        checkOutput({tag, "_valid"}, int'(signal_valid), mV2);
        checkOutput({tag, "_wrap"}, int'(wrap), mWrap);
    endtask

    task automatic startRun(input logic [1:0] c, input logic [15:0] inc, input logic [15:0] off);
        applyStimulus(1'b1, 1'b0, c, 16'h0, 1'b0, off);
        applyStimulus(1'b0, 1'b0, c, inc, 1'b1, off);
    endtask

    // Main test sequence.
    initial begin
        int found;
        int expPhase;

        vecs[0] = '{1'b1, 1'b0, 2'd1, 16'h0000, 1'b0, 16'h0, 0, 0, 0, 0};
        vecs[1] = '{1'b0, 1'b0, 2'd1, 16'h1000, 1'b1, 16'h0, 0, 0, 0, 0};
        vecs[2] = '{1'b0, 1'b1, 2'd1, 16'h0000, 1'b0, 16'h0, 16'h1000, 0, 0, 0};
        vecs[3] = '{1'b0, 1'b1, 2'd1, 16'h0000, 1'b0, 16'h0, 16'h2000, 0, 1, 0};
        vecs[4] = '{1'b0, 1'b1, 2'd1, 16'h0000, 1'b0, 16'h0, 16'h3000, 8'h10, 1, 0};
        vecs[5] = '{1'b0, 1'b1, 2'd1, 16'h0000, 1'b0, 16'h0, 16'h4000, 8'h20, 1, 0};
        vecs[6] = '{1'b0, 1'b1, 2'd1, 16'h0000, 1'b0, 16'h0, 16'h5000, 8'h30, 1, 0};
        vecs[7] = '{1'b0, 1'b1, 2'd1, 16'h0000, 1'b0, 16'h0, 16'h6000, 8'h40, 1, 0};

        // Load then sawtooth run
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].r, vecs[i].e, vecs[i].c, vecs[i].inc, vecs[i].ld, vecs[i].off);
            checkOutput($sformatf("vec%0d_phase", i), int'(phase_out), vecs[i].ePhase);
            checkOutput($sformatf("vec%0d_signal", i), int'(signal_out), vecs[i].eSig);
            checkOutput($sformatf("vec%0d_valid", i), int'(signal_valid), vecs[i].eValid);
            checkOutput($sformatf("vec%0d_wrap", i), int'(wrap), vecs[i].eWrap);
        end
        for (int n = 8; n < 25; n++) begin
            applyStimulus(1'b0, 1'b1, 2'd1, 16'h0, 1'b0, 16'h0);
            expPhase = ((n - 1) * 4096) % 65536;
            checkOutput("saw_phase", int'(phase_out), expPhase);
            checkOutput("saw_wrap", int'(wrap), (expPhase == 0) ? 1 : 0);
            checkOutput("saw_signal", int'(signal_out), ((n - 3) * 16) % 256);
        end

        // Square with half-period offset
        startRun(2'd0, 16'h1000, 16'h8000);
        for (int n = 0; n < 34; n++) begin
            applyStimulus(1'b0, 1'b1, 2'd0, 16'h0, 1'b0, 16'h8000);
            hist[n] = int'(phase_out);
            if (n >= 2) checkOutput("square", int'(signal_out), (hist[n-2] < 32768) ? 0 : 255);
        end

        // Sine: full period capture, fixed points and half-wave antisymmetry
        startRun(2'd3, 16'h0100, 16'h0);
        for (int n = 0; n < 258; n++) begin
            applyStimulus(1'b0, 1'b1, 2'd3, 16'h0, 1'b0, 16'h0);
            hist[n] = int'(phase_out);
            if (n >= 2) sineAt[hist[n-2] / 256] = int'(signal_out);
        end
        checkOutput("sine_0000", sineAt[8'h00], 130);
        checkOutput("sine_3F00", sineAt[8'h3F], 255);
        checkOutput("sine_8000", sineAt[8'h80], 125);
        checkOutput("sine_BF00", sineAt[8'hBF], 0);
        for (int t = 0; t < 128; t++) begin
            checkOutput($sformatf("sine_antisym%0d", t), sineAt[t] + sineAt[t + 128], 255);
        end

        // Triangle
        startRun(2'd2, 16'h0800, 16'h0);
        for (int n = 0; n < 36; n++) begin
            applyStimulus(1'b0, 1'b1, 2'd2, 16'h0, 1'b0, 16'h0);
            hist[n] = int'(phase_out);
            if (n >= 2) begin
                checkOutput("triangle", int'(signal_out),
                            (hist[n-2] < 32768) ? hist[n-2] / 128 : 255 - ((hist[n-2] - 32768) / 128));
            end
        end

        // Glitch-free retune: load mid-period, then load on a wrap edge
        startRun(2'd1, 16'h1000, 16'h0);
        found = 0;
        for (int n = 0; n < 40 && found == 0; n++) begin
            applyStimulus(1'b0, 1'b1, 2'd1, 16'h0, 1'b0, 16'h0);
            if (phase_out == 16'h5000) found = 1;
        end
        checkOutput("retune_reach5000", found, 1);
        applyStimulus(1'b0, 1'b1, 2'd1, 16'h2000, 1'b1, 16'h0);
        checkOutput("retune_6000", int'(phase_out), 16'h6000);
        for (int k = 7; k < 16; k++) begin
            applyStimulus(1'b0, 1'b1, 2'd1, 16'h0, 1'b0, 16'h0);
            checkOutput("retune_old_phase", int'(phase_out), k * 4096);
            checkOutput("retune_old_wrap", int'(wrap), 0);
        end
        applyStimulus(1'b0, 1'b1, 2'd1, 16'h0, 1'b0, 16'h0);
        checkOutput("retune_wrap_phase", int'(phase_out), 0);
        checkOutput("retune_wrap", int'(wrap), 1);
        applyStimulus(1'b0, 1'b1, 2'd1, 16'h0, 1'b0, 16'h0);
        checkOutput("retune_new_2000", int'(phase_out), 16'h2000);
        applyStimulus(1'b0, 1'b1, 2'd1, 16'h0, 1'b0, 16'h0);
        checkOutput("retune_new_4000", int'(phase_out), 16'h4000);
        found = 0;
        for (int n = 0; n < 20 && found == 0; n++) begin
            applyStimulus(1'b0, 1'b1, 2'd1, 16'h0, 1'b0, 16'h0);
            if (phase_out == 16'hE000) found = 1;
        end
        checkOutput("retune_reachE000", found, 1);
        applyStimulus(1'b0, 1'b1, 2'd1, 16'h3000, 1'b1, 16'h0);
        checkOutput("wrapload_phase", int'(phase_out), 0);
        checkOutput("wrapload_wrap", int'(wrap), 1);
        applyStimulus(1'b0, 1'b1, 2'd1, 16'h0, 1'b0, 16'h0);
        checkOutput("wrapload_3000", int'(phase_out), 16'h3000);

        // Mid-run reset with a simultaneous load
        applyStimulus(1'b1, 1'b1, 2'd1, 16'h0400, 1'b1, 16'h0);
        checkOutput("rst_phase", int'(phase_out), 0);
        checkOutput("rst_signal", int'(signal_out), 0);
        checkOutput("rst_valid", int'(signal_valid), 0);
        checkOutput("rst_wrap", int'(wrap), 0);
        for (int n = 0; n < 3; n++) begin
            applyStimulus(1'b0, 1'b1, 2'd1, 16'h0, 1'b0, 16'h0);
            checkOutput("rst_stationary", int'(phase_out), 0);
        end

        // Randomized traffic against the reference model
        for (int n = 0; n < 800; n++) begin
            applyStimulus(($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0,
                          ($urandom_range(0, 4) != 0) ? 1'b1 : 1'b0,
                          2'($urandom_range(0, 3)),
                          ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 4095)) : 16'($urandom),
                          ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0,
                          16'($urandom));
            checkAll("rand");
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
